pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit.sv | 96 +++++++++
 tb/tb_pc_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch sequencer (IDLE/FETCH/EXEC/TRAP)
// Ports: clk/rst_n (sync active-low), stall, next_pc, imem_ack/imem_rdata in;
//   imem_req/imem_addr fetch request, instr/instr_valid, pc/pc_plus4, trap/trap_cause/trap_pc out.
// Optional: define PC_FETCH_RETIRE_COUNT_EN to add retired_count (count of EXEC->FETCH exits).
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] next_pc,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
`ifdef PC_FETCH_RETIRE_COUNT_EN
  output logic [31:0] retired_count,
`endif
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] trap_pc
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, TRAP} state_t;
  localparam logic [7:0] CNT_MAX = 8'(ACK_TIMEOUT - 1);
  state_t state;
  logic [7:0] cnt;
  assign imem_addr = pc;
  assign pc_plus4 = pc + 32'd4;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      cnt <= '0;
      instr <= '0;
      instr_valid <= 1'b0;
      imem_req <= 1'b0;
      trap <= 1'b0;
      trap_cause <= 2'b00;
      trap_pc <= '0;
`ifdef PC_FETCH_RETIRE_COUNT_EN
      retired_count <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          imem_req <= 1'b1;
          cnt <= '0;
        end
        FETCH: begin
          // an ack on the expiry cycle still wins over the timeout
          if (imem_ack) begin
            instr <= imem_rdata;
            cnt <= '0;
            state <= EXEC;
            imem_req <= 1'b0;
            instr_valid <= 1'b1;
          end else if (cnt == CNT_MAX) begin
            state <= TRAP;
            imem_req <= 1'b0;
            trap <= 1'b1;
            trap_cause <= 2'b10;
            trap_pc <= pc;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        EXEC: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            if (next_pc[1:0] != 2'b00) begin
              state <= TRAP;
              trap <= 1'b1;
              trap_cause <= 2'b01;
              trap_pc <= next_pc;
            end else begin
              pc <= next_pc;
              state <= FETCH;
              imem_req <= 1'b1;
              cnt <= '0;
`ifdef PC_FETCH_RETIRE_COUNT_EN
              retired_count <= retired_count + 32'd1;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed bench for pc_fetch_unit with RESET_PC=0x0040_0000, ACK_TIMEOUT=4
module tb_pc_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, imem_ack = 1'b0;
  logic [31:0] next_pc = '0, imem_rdata = '0;
  logic imem_req, instr_valid, trap;
  logic [31:0] imem_addr, instr, pc, pc_plus4, trap_pc;
  logic [1:0] trap_cause;
`ifdef PC_FETCH_RETIRE_COUNT_EN
  logic [31:0] retired_count;
`endif
  int vecs = 0, errs = 0;
  pc_fetch_unit #(.RESET_PC(32'h0040_0000), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .next_pc(next_pc),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
`ifdef PC_FETCH_RETIRE_COUNT_EN
    .retired_count(retired_count),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .trap(trap), .trap_cause(trap_cause), .trap_pc(trap_pc));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic go_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0;
    stall = 1'b0;
    step();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    go_reset();
    vecs++;
    if ({pc, instr, imem_req, instr_valid, trap, trap_cause, trap_pc} !== {32'h0040_0000, 32'h0, 3'b000, 2'b00, 32'h0}) begin
      errs++;
      $display("FAIL reset_state: pc=%h instr=%h req/val/trap=%b%b%b cause=%b tpc=%h", pc, instr, imem_req, instr_valid, trap, trap_cause, trap_pc);
    end
    step();
    vecs++;
    if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0040_0000, 1'b0}) begin
      errs++;
      $display("FAIL first_fetch: req=%b addr=%h valid=%b want 1 00400000 0", imem_req, imem_addr, instr_valid);
    end
    imem_ack = 1'b1;
    imem_rdata = 32'h2008_0005;
    step();
    imem_ack = 1'b0;
    vecs++;
    if ({instr, instr_valid, imem_req, pc_plus4} !== {32'h2008_0005, 1'b1, 1'b0, 32'h0040_0004}) begin
      errs++;
      $display("FAIL first_exec: instr=%h valid=%b req=%b pc4=%h want 20080005 1 0 00400004", instr, instr_valid, imem_req, pc_plus4);
    end
  endtask
  task automatic test_stall();
    stall = 1'b1;
    next_pc = 32'h0040_0004;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      imem_ack = i[0];
      step();
      vecs++;
      if ({pc, instr, instr_valid, imem_req} !== {32'h0040_0000, 32'h2008_0005, 1'b1, 1'b0}) begin
        errs++;
        $display("FAIL stall_hold%0d: pc=%h instr=%h valid=%b req=%b", i, pc, instr, instr_valid, imem_req);
      end
    end
    imem_ack = 1'b0;
    stall = 1'b0;
    step();
    vecs++;
    if ({pc, imem_req, imem_addr, instr_valid} !== {32'h0040_0004, 1'b1, 32'h0040_0004, 1'b0}) begin
      errs++;
      $display("FAIL stall_release: pc=%h req=%b addr=%h valid=%b want 00400004 1 00400004 0", pc, imem_req, imem_addr, instr_valid);
    end
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_0020;
    step();
    imem_ack = 1'b0;
    vecs++;
    if ({instr, instr_valid} !== {32'h0000_0020, 1'b1}) begin
      errs++;
      $display("FAIL second_exec: instr=%h valid=%b want 00000020 1", instr, instr_valid);
    end
  endtask
  task automatic test_misalign();
    next_pc = 32'h0040_0006;
    step();
    next_pc = 32'h0040_0008;
    vecs++;
    if ({trap, trap_cause, trap_pc, pc, instr_valid, imem_req} !== {1'b1, 2'b01, 32'h0040_0006, 32'h0040_0004, 2'b00}) begin
      errs++;
      $display("FAIL misalign_trap: trap=%b cause=%b tpc=%h pc=%h valid=%b req=%b", trap, trap_cause, trap_pc, pc, instr_valid, imem_req);
    end
    for (int i = 0; i < 4; i++) begin
      imem_ack = ~imem_ack;
      step();
    end
    vecs++;
    if ({trap, trap_cause, trap_pc, pc, instr_valid, imem_req} !== {1'b1, 2'b01, 32'h0040_0006, 32'h0040_0004, 2'b00}) begin
      errs++;
      $display("FAIL trap_sticky: trap=%b cause=%b tpc=%h pc=%h valid=%b req=%b", trap, trap_cause, trap_pc, pc, instr_valid, imem_req);
    end
    go_reset();
    vecs++;
    if ({trap, trap_cause, trap_pc, pc} !== {1'b0, 2'b00, 32'h0, 32'h0040_0000}) begin
      errs++;
      $display("FAIL trap_clear: trap=%b cause=%b tpc=%h pc=%h", trap, trap_cause, trap_pc, pc);
    end
  endtask
  task automatic test_timeout();
    go_reset();
    step();
    for (int i = 0; i < 3; i++) step();
    vecs++;
    if ({trap, imem_req} !== 2'b01) begin
      errs++;
      $display("FAIL timeout_early: trap=%b req=%b want 0 1", trap, imem_req);
    end
    step();
    vecs++;
    if ({trap, trap_cause, trap_pc, imem_req} !== {1'b1, 2'b10, 32'h0040_0000, 1'b0}) begin
      errs++;
      $display("FAIL timeout_trap: trap=%b cause=%b tpc=%h req=%b", trap, trap_cause, trap_pc, imem_req);
    end
    go_reset();
    step();
    for (int i = 0; i < 3; i++) step();
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    vecs++;
    if ({trap, instr_valid, instr} !== {1'b0, 1'b1, 32'h1234_5678}) begin
      errs++;
      $display("FAIL ack_at_expiry: trap=%b valid=%b instr=%h want 0 1 12345678", trap, instr_valid, instr);
    end
  endtask
  task automatic test_wrap();
    next_pc = 32'hFFFF_FFFC;
    step();
    vecs++;
    if ({pc, pc_plus4} !== {32'hFFFF_FFFC, 32'h0}) begin
      errs++;
      $display("FAIL pc_wrap: pc=%h pc4=%h want fffffffc 00000000", pc, pc_plus4);
    end
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    next_pc = 32'h0;
    step();
    vecs++;
    if ({pc, imem_req, pc_plus4} !== {32'h0, 1'b1, 32'h4}) begin
      errs++;
      $display("FAIL next_pc_zero: pc=%h req=%b pc4=%h want 0 1 4", pc, imem_req, pc_plus4);
    end
  endtask
  task automatic test_reset_mid_fetch();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vecs++;
    if ({pc, imem_req, instr_valid, instr, trap} !== {32'h0040_0000, 2'b00, 32'h0, 1'b0}) begin
      errs++;
      $display("FAIL reset_mid_fetch: pc=%h req=%b valid=%b instr=%h trap=%b", pc, imem_req, instr_valid, instr, trap);
    end
  endtask
`ifdef PC_FETCH_RETIRE_COUNT_EN
  task automatic test_retire();
    go_reset();
    step();
    next_pc = 32'h0040_0010;
    stall = 1'b1;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      imem_ack = 1'b1;
      step();
      imem_ack = 1'b0;
    end
    vecs++;
    if (retired_count !== 32'd3) begin
      errs++;
      $display("FAIL retire_count: got %0d want 3", retired_count);
    end
    go_reset();
    vecs++;
    if (retired_count !== 32'd0) begin
      errs++;
      $display("FAIL retire_reset: got %0d want 0", retired_count);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_stall();
    test_misalign();
    test_timeout();
    test_wrap();
    test_reset_mid_fetch();
`ifdef PC_FETCH_RETIRE_COUNT_EN
    test_retire();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
